// File: rtl/wb_bus_pkg.sv
// rtl/wb_bus_pkg.sv - shared decode constants, state type and helpers for the Wishbone bus guard
package wb_bus_pkg;

  localparam int NSLV     = 5;
  localparam int SLV_RAM  = 0;
  localparam int SLV_ROM  = 1;
  localparam int SLV_UART = 2;
  localparam int SLV_GPIO = 3;
  localparam int SLV_SPI  = 4;

  localparam int SPI_RAM_BIT = 31;
  localparam int SPI_ROM_BIT = 30;
  localparam int UART_BIT    = 29;
  localparam int GPIO_BIT    = 28;
  localparam int SPI1_BIT    = 27;
  localparam int SPI2_BIT    = 26;
  localparam int SPI3_BIT    = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR_ACK
  } state_e;

  // SPI chip-select bits collapse into one region so a multi-CS address still hits one slave.
  function automatic logic [NSLV-1:0] adr_region(input logic [31:0] adr);
    return {adr[SPI1_BIT] | adr[SPI2_BIT] | adr[SPI3_BIT],
            adr[GPIO_BIT], adr[UART_BIT], adr[SPI_ROM_BIT], adr[SPI_RAM_BIT]};
  endfunction

  function automatic logic region_valid(input logic [NSLV-1:0] r);
    return $countones(r) == 1;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - 10-bit wait counter with clear, enable and expire flag
module wb_timeout_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [9:0] limit,
  output logic       expire
);

  logic [9:0] cnt;

  // Holds at the limit so a lingering enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !expire)
      cnt <= cnt + 10'd1;
  end

  assign expire = (cnt == limit);

endmodule

// File: rtl/wb_bus_guard.sv
// rtl/wb_bus_guard.sv - registered Wishbone address decoder with error ack and bus-timeout watchdog
module wb_bus_guard
  import wb_bus_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  input  logic                 m_we_i,
  input  logic [3:0]           m_sel_i,
  input  logic [31:0]          m_adr_i,
  output logic [31:0]          m_dat_o,
  output logic                 m_ack_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic                 s_stb_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [32*NSLV-1:0]   s_dat_i,
  output logic                 err_o,
  output logic [31:0]          fault_adr_o,
  output logic [7:0]           fault_cnt_o
);

  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT - 1);

  state_e          state;
  logic [NSLV-1:0] sel_q;
  logic [NSLV-1:0] region_v;
  logic [NSLV-1:0] hit;
  logic            req, valid, busy, in_err, acked, tmo_expire;
  logic            unused_passthru;

  // we/sel reach the slaves directly in the top level; the guard only watches the handshake.
  assign unused_passthru = ^{m_we_i, m_sel_i};

  assign region_v = adr_region(m_adr_i);
  assign valid    = region_valid(region_v);
  assign req      = m_cyc_i & m_stb_i;
  assign busy     = (state == ST_BUSY);
  assign in_err   = (state == ST_ERR_ACK);
  assign hit      = s_ack_i & sel_q;
  assign acked    = busy & m_cyc_i & (|hit);

  wb_timeout_cnt u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    ((state == ST_IDLE) && req && valid),
    .en     (busy && m_cyc_i && !(|hit)),
    .limit  (TMO_LIMIT),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      fault_adr_o <= '0;
      fault_cnt_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (valid) begin
              sel_q <= region_v;
              state <= ST_BUSY;
            end else begin
              state <= ST_ERR_ACK;
            end
          end
        end
        ST_BUSY: begin
          // An abort or an ack on the last allowed cycle both beat the timeout.
          if (!m_cyc_i || (|hit))
            state <= ST_IDLE;
          else if (tmo_expire)
            state <= ST_ERR_ACK;
        end
        ST_ERR_ACK: begin
          fault_adr_o <= m_adr_i;
          if (fault_cnt_o != 8'hFF)
            fault_cnt_o <= fault_cnt_o + 8'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_cyc_o = busy ? sel_q : '0;
  assign s_stb_o = busy & m_stb_i;
  assign m_ack_o = acked | in_err;
  assign err_o   = in_err;

  always_comb begin
    m_dat_o = '0;
    if (in_err) begin
      m_dat_o = ERR_DATA;
    end else if (acked) begin
      for (int k = 0; k < NSLV; k++)
        if (sel_q[k])
          m_dat_o = m_dat_o | s_dat_i[32*k +: 32];
    end
  end

endmodule

// File: tb/tb_wb_bus_guard.sv
// tb/tb_wb_bus_guard.sv - directed scoreboard bench for wb_bus_guard with TIMEOUT=8
module tb_wb_bus_guard;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_cyc_i, m_stb_i, m_we_i;
  logic [3:0]   m_sel_i;
  logic [31:0]  m_adr_i;
  logic [31:0]  m_dat_o;
  logic         m_ack_o;
  logic [4:0]   s_cyc_o;
  logic         s_stb_o;
  logic [4:0]   s_ack_i;
  logic [159:0] s_dat_i;
  logic         err_o;
  logic [31:0]  fault_adr_o;
  logic [7:0]   fault_cnt_o;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_n   = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   exp_fcnt;
  int   t0;

  localparam logic [31:0] D_RAM  = 32'h2222_0000;
  localparam logic [31:0] D_ROM  = 32'h1111_0001;
  localparam logic [31:0] D_UART = 32'h0000_0041;
  localparam logic [31:0] D_GPIO = 32'h6666_0003;
  localparam logic [31:0] D_SPI  = 32'h5555_0004;
  localparam logic [31:0] D_ERR  = 32'hDEADBEEF;

  wb_bus_guard #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_cyc_i     (m_cyc_i),
    .m_stb_i     (m_stb_i),
    .m_we_i      (m_we_i),
    .m_sel_i     (m_sel_i),
    .m_adr_i     (m_adr_i),
    .m_dat_o     (m_dat_o),
    .m_ack_o     (m_ack_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_ack_i     (s_ack_i),
    .s_dat_i     (s_dat_i),
    .err_o       (err_o),
    .fault_adr_o (fault_adr_o),
    .fault_cnt_o (fault_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] adr, input logic we);
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_we_i  = we;
    m_adr_i = adr;
    t0      = cyc_n;
  endtask

  task automatic release_bus();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    s_ack_i = '0;
  endtask

  task automatic expect_ack(input int cyc, input logic [31:0] dat, input logic err);
    exp_t e;
    e.cyc = cyc;
    e.dat = dat;
    e.err = err;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_ack_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack_cycle", cyc_n, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_cycle", cyc_n, e.cyc);
          check("ack_data", m_dat_o, e.dat);
          check("ack_err", {31'b0, err_o}, {31'b0, e.err});
        end
      end else begin
        check("idle_dat", m_dat_o, 32'h0);
        check("idle_err", {31'b0, err_o}, 32'h0);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    m_sel_i = 4'hF;
    m_adr_i = '0;
    s_ack_i = '0;
    s_dat_i = {D_SPI, D_GPIO, D_UART, D_ROM, D_RAM};

    @(negedge clk);
    check("rst_s_cyc", {27'b0, s_cyc_o}, 32'h0);
    check("rst_s_stb", {31'b0, s_stb_o}, 32'h0);
    check("rst_ack", {31'b0, m_ack_o}, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_dat", m_dat_o, 32'h0);
    check("rst_fadr", fault_adr_o, 32'h0);
    check("rst_fcnt", {24'b0, fault_cnt_o}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // UART read, zero-wait ack
    request(32'h2000_0004, 1'b0);
    expect_ack(t0 + 1, D_UART, 1'b0);
    tick();
    s_ack_i = 5'b00100;
    @(negedge clk);
    check("uart_s_cyc", {27'b0, s_cyc_o}, 32'h04);
    check("uart_s_stb", {31'b0, s_stb_o}, 32'h1);
    tick();
    release_bus();
    @(negedge clk);
    check("uart_turnaround_s_cyc", {27'b0, s_cyc_o}, 32'h0);
    tick();

    // Unmapped read
    request(32'h0000_1000, 1'b0);
    expect_ack(t0 + 1, D_ERR, 1'b1);
    tick();
    @(negedge clk);
    check("unmapped_s_cyc", {27'b0, s_cyc_o}, 32'h0);
    tick();
    release_bus();
    @(negedge clk);
    check("unmapped_fadr", fault_adr_o, 32'h0000_1000);
    check("unmapped_fcnt", {24'b0, fault_cnt_o}, 32'd1);
    tick();

    // RAM and ROM both hit
    request(32'hC000_0000, 1'b0);
    expect_ack(t0 + 1, D_ERR, 1'b1);
    @(negedge clk);
    check("multi_s_cyc_c0", {27'b0, s_cyc_o}, 32'h0);
    tick();
    @(negedge clk);
    check("multi_s_cyc_c1", {27'b0, s_cyc_o}, 32'h0);
    tick();
    release_bus();
    @(negedge clk);
    check("multi_s_cyc_c2", {27'b0, s_cyc_o}, 32'h0);
    check("multi_fcnt", {24'b0, fault_cnt_o}, 32'd2);
    tick();

    // Two SPI chip-select bits count as a single SPI hit
    request(32'h0600_0000, 1'b0);
    expect_ack(t0 + 1, D_SPI, 1'b0);
    tick();
    s_ack_i = 5'b10000;
    @(negedge clk);
    check("spi2cs_s_cyc", {27'b0, s_cyc_o}, 32'h10);
    tick();
    release_bus();
    tick();

    // GPIO never acks: timeout
    request(32'h1000_0000, 1'b0);
    expect_ack(t0 + 9, D_ERR, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("tmo_s_cyc_c%0d", i), {27'b0, s_cyc_o}, 32'h08);
    end
    tick();
    @(negedge clk);
    check("tmo_err_s_cyc", {27'b0, s_cyc_o}, 32'h0);
    tick();
    release_bus();
    @(negedge clk);
    check("tmo_fadr", fault_adr_o, 32'h1000_0000);
    check("tmo_fcnt", {24'b0, fault_cnt_o}, 32'd3);
    tick();

    // GPIO acks on the last allowed cycle
    request(32'h1000_0000, 1'b0);
    expect_ack(t0 + 8, D_GPIO, 1'b0);
    for (int i = 1; i <= 7; i++) tick();
    tick();
    s_ack_i = 5'b01000;
    tick();
    release_bus();
    @(negedge clk);
    check("late_ack_fcnt", {24'b0, fault_cnt_o}, 32'd3);
    tick();

    // SPI write with a stray RAM ack; SPI acks at cycle 3
    request(32'h0800_0000, 1'b1);
    expect_ack(t0 + 3, D_SPI, 1'b0);
    tick();
    s_ack_i = 5'b00001;
    tick();
    tick();
    s_ack_i = 5'b10001;
    tick();
    release_bus();
    tick();

    // Same write, master aborts at cycle 2
    request(32'h0800_0000, 1'b1);
    tick();
    s_ack_i = 5'b00001;
    @(negedge clk);
    check("abort_s_cyc_c1", {27'b0, s_cyc_o}, 32'h10);
    tick();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    tick();
    @(negedge clk);
    check("abort_s_cyc_c3", {27'b0, s_cyc_o}, 32'h0);
    check("abort_fcnt", {24'b0, fault_cnt_o}, 32'd3);
    release_bus();
    tick();

    // Fault counter saturation
    exp_fcnt = 3;
    for (int i = 0; i < 260; i++) begin
      request(32'h0000_0100 + 32'(i * 4), 1'b0);
      expect_ack(t0 + 1, D_ERR, 1'b1);
      tick();
      tick();
      release_bus();
      if (exp_fcnt < 255) exp_fcnt++;
      @(negedge clk);
      check($sformatf("sat_fcnt_%0d", i), {24'b0, fault_cnt_o}, 32'(exp_fcnt));
      tick();
    end
    check("sat_fadr", fault_adr_o, 32'h0000_0100 + 32'(259 * 4));

    // Asynchronous reset in the middle of a BUSY access
    request(32'h2000_0000, 1'b0);
    tick();
    @(negedge clk);
    check("rstbusy_s_cyc_before", {27'b0, s_cyc_o}, 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstbusy_s_cyc", {27'b0, s_cyc_o}, 32'h0);
    check("rstbusy_s_stb", {31'b0, s_stb_o}, 32'h0);
    check("rstbusy_ack", {31'b0, m_ack_o}, 32'h0);
    check("rstbusy_err", {31'b0, err_o}, 32'h0);
    check("rstbusy_dat", m_dat_o, 32'h0);
    check("rstbusy_fadr", fault_adr_o, 32'h0);
    check("rstbusy_fcnt", {24'b0, fault_cnt_o}, 32'h0);
    release_bus();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
